// File: rtl/pipe_mdu_exe.sv
// EX-stage iterative multiply/divide unit: 33-cycle MULT/MULTU/DIV/DIVU into HI/LO,
// with MTHI/MTLO writes, flush abort and a registered pipeline stall.
module pipe_mdu_exe (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_whi,
  input  logic        i_wlo,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        negq_q, negq_d, negr_q, negr_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic        is_signed;
  logic [31:0] abs_a, abs_b;
  logic [32:0] msum, ddiff;
  logic [63:0] neg_acc;

  assign is_signed = ~i_op[0];
  assign abs_a     = (is_signed && i_a[31]) ? -i_a : i_a;
  assign abs_b     = (is_signed && i_b[31]) ? -i_b : i_b;

  // Multiply step: conditional add of the multiplicand into P, carry kept for the shift.
  assign msum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
  // Divide step: acc_q[63:31] is the shifted remainder incl. the bit leaving R.
  assign ddiff   = acc_q[63:31] - {1'b0, b_q};
  assign neg_acc = -acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_whi) hi_d = i_a;
        if (i_wlo) lo_d = i_a;
        if (i_start && !i_flush) begin
          op_d    = i_op;
          negq_d  = is_signed & (i_a[31] ^ i_b[31]);
          negr_d  = is_signed & i_a[31];
          b_d     = abs_b;
          acc_d   = {32'd0, abs_a};
          cnt_d   = 6'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (i_flush) begin
          state_d = IDLE;
        end else begin
          if (!op_q[1])
            acc_d = {msum, acc_q[31:1]};
          else if (!ddiff[32])
            acc_d = {ddiff[31:0], acc_q[30:0], 1'b1};
          else
            acc_d = {acc_q[62:0], 1'b0};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!i_flush) begin
          done_d = 1'b1;
          if (!op_q[1]) begin
            {hi_d, lo_d} = negq_q ? neg_acc : acc_q;
          end else begin
            lo_d = negq_q ? neg_acc[31:0] : acc_q[31:0];
            hi_d = negr_q ? -acc_q[63:32] : acc_q[63:32];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_stall = busy_q;
  assign o_done  = done_q;
  assign o_hi    = hi_q;
  assign o_lo    = lo_q;
endmodule
